// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hilo_pkg
// Brief    : Shared encodings for the HI/LO multiply/divide resource:
//            E-stage op codes, read selects and controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package hilo_pkg;

    // Op encodings; these match the decoder's hiloOpD field.
    localparam logic [2:0] HILO_NONE  = 3'b000;
    localparam logic [2:0] HILO_MULT  = 3'b001;
    localparam logic [2:0] HILO_MULTU = 3'b010;
    localparam logic [2:0] HILO_DIV   = 3'b011;
    localparam logic [2:0] HILO_DIVU  = 3'b100;
    localparam logic [2:0] HILO_MTHI  = 3'b101;
    localparam logic [2:0] HILO_MTLO  = 3'b110;

    // Read selects for mfhi/mflo.
    localparam logic [1:0] HILO_RD_HI = 2'b10;
    localparam logic [1:0] HILO_RD_LO = 2'b01;

    // Controller state encoding.
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // True for the four multi-cycle arithmetic ops.
    function automatic logic is_md_op(input logic [2:0] op);
        return (op == HILO_MULT) || (op == HILO_MULTU) ||
               (op == HILO_DIV)  || (op == HILO_DIVU);
    endfunction

    // True for div/divu, which take the longer latency.
    function automatic logic is_div_op(input logic [2:0] op);
        return (op == HILO_DIV) || (op == HILO_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_ctrl_md_arith.sv
`default_nettype none
// ============================================================================
// Module   : md_arith
// Brief    : Combinational multiply/divide datapath. Produces the HI/LO pair
//            for mult/multu/div/divu and flags a zero divisor on div ops.
// Revision : 1.0 - initial release
// ============================================================================
module md_arith
    import hilo_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div_zero
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic        [31:0] w_b_safe;
    logic signed [31:0] w_a_s;
    logic signed [31:0] w_b_s;
    logic signed [31:0] w_quo_s;
    logic signed [31:0] w_rem_s;
    logic        [31:0] w_quo_u;
    logic        [31:0] w_rem_u;
    logic               w_b_zero;

    assign w_b_zero = (i_b == 32'd0);

    // Substitute a divisor of 1 when b is zero so the dividers never see an
    // undefined operation; the result is discarded by the controller anyway.
    assign w_b_safe = w_b_zero ? 32'd1 : i_b;

    assign w_a_s    = $signed(i_a);
    assign w_b_s    = $signed(w_b_safe);

    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // SV signed division truncates toward zero; remainder takes dividend sign.
    assign w_quo_s  = w_a_s / w_b_s;
    assign w_rem_s  = w_a_s % w_b_s;
    assign w_quo_u  = i_a / w_b_safe;
    assign w_rem_u  = i_a % w_b_safe;

    // Select the result pair for the requested op.
    always_comb begin
        o_hi       = 32'd0;
        o_lo       = 32'd0;
        o_div_zero = 1'b0;
        case (i_op)
            HILO_MULT: begin
                o_hi = w_prod_s[63:32];
                o_lo = w_prod_s[31:0];
            end
            HILO_MULTU: begin
                o_hi = w_prod_u[63:32];
                o_lo = w_prod_u[31:0];
            end
            HILO_DIV: begin
                o_hi       = w_rem_s;
                o_lo       = w_quo_s;
                o_div_zero = w_b_zero;
            end
            HILO_DIVU: begin
                o_hi       = w_rem_u;
                o_lo       = w_quo_u;
                o_div_zero = w_b_zero;
            end
            default: begin
                o_hi       = 32'd0;
                o_lo       = 32'd0;
                o_div_zero = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hilo_ctrl
// Brief    : E-stage sequencing controller for the HI/LO mult/div unit. Owns
//            HI and LO, models mult/div latency with a busy counter, commits
//            results on completion and stalls D-stage HI/LO instructions.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  hiloOpE,
    input  logic [1:0]  hiloReadE,
    input  logic [31:0] rsE,
    input  logic [31:0] rtE,
    input  logic        isHiloD,
    output logic        start,
    output logic        busy,
    output logic        stallHiloD,
    output logic [31:0] hiloOutE
);

    localparam logic [CNT_W-1:0] c_MULT_LD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] c_DIV_LD  = CNT_W'(DIV_CYC);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_busy;

    logic             w_start;
    logic [31:0]      w_arith_hi;
    logic [31:0]      w_arith_lo;
    logic             w_div_zero;

    md_arith u_md_arith (
        .i_op       (hiloOpE),
        .i_a        (rsE),
        .i_b        (rtE),
        .o_hi       (w_arith_hi),
        .o_lo       (w_arith_lo),
        .o_div_zero (w_div_zero)
    );

    // A new mult/div is accepted only while idle; ops arriving while busy are dropped.
    assign w_start    = (r_state == IDLE) && is_md_op(hiloOpE);
    assign start      = w_start;
    assign busy       = r_busy;
    // A mult/div sitting in E blocks the D-stage instruction even before busy rises.
    assign stallHiloD = isHiloD && (w_start || r_busy);

    // Controller FSM: latch result on start, count down, commit on the last busy cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        // A zero divisor re-commits the current HI/LO, leaving
                        // them unchanged; nothing can write them while busy.
                        r_pend_hi <= w_div_zero ? r_hi : w_arith_hi;
                        r_pend_lo <= w_div_zero ? r_lo : w_arith_lo;
                        r_cnt     <= is_div_op(hiloOpE) ? c_DIV_LD : c_MULT_LD;
                        r_state   <= BUSY;
                        r_busy    <= 1'b1;
                    end else if (hiloOpE == HILO_MTHI) begin
                        r_hi <= rsE;
                    end else if (hiloOpE == HILO_MTLO) begin
                        r_lo <= rsE;
                    end
                end
                BUSY: begin
                    if (r_cnt == c_ONE) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read port straight from the architectural registers; no pending bypass.
    always_comb begin
        hiloOutE = 32'd0;
        case (hiloReadE)
            HILO_RD_HI: hiloOutE = r_hi;
            HILO_RD_LO: hiloOutE = r_lo;
            default:    hiloOutE = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_ctrl
// Brief    : Self-checking bench for hilo_ctrl: directed vector table for the
//            mult/div ops plus hand-written mthi/mtlo and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_ctrl;
    import hilo_pkg::*;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic        clk;
    logic        rst;
    logic [2:0]  hiloOpE;
    logic [1:0]  hiloReadE;
    logic [31:0] rsE;
    logic [31:0] rtE;
    logic        isHiloD;
    logic        start;
    logic        busy;
    logic        stallHiloD;
    logic [31:0] hiloOutE;

    int checks;
    int errors;

    hilo_ctrl #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (4)
    ) dut (
        .clk        (clk),
        .reset      (rst),
        .hiloOpE    (hiloOpE),
        .hiloReadE  (hiloReadE),
        .rsE        (rsE),
        .rtE        (rtE),
        .isHiloD    (isHiloD),
        .start      (start),
        .busy       (busy),
        .stallHiloD (stallHiloD),
        .hiloOutE   (hiloOutE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        hd;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next cycle: inputs are driven 1 time unit after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
        hiloReadE = HILO_RD_HI;
        #1 chk({tag, " mfhi"}, hiloOutE, exp_hi);
        hiloReadE = HILO_RD_LO;
        #1 chk({tag, " mflo"}, hiloOutE, exp_lo);
        hiloReadE = 2'b11;
        #1 chk({tag, " rd11"}, hiloOutE, 32'd0);
        hiloReadE = 2'b00;
    endtask

    // Issue one mult/div in cycle 0, then check busy/stall through cycle N+1 and results.
    task automatic run_op(input vec_t v, input string tag);
        int n;
        n = is_div_op(v.op) ? DIV_CYC : MULT_CYC;
        next_cycle();
        hiloOpE   = v.op;
        rsE       = v.a;
        rtE       = v.b;
        isHiloD   = v.hd;
        hiloReadE = 2'b00;
        #1;
        chk({tag, " start c0"}, {31'd0, start}, 32'd1);
        chk({tag, " busy c0"}, {31'd0, busy}, 32'd0);
        chk({tag, " stall c0"}, {31'd0, stallHiloD}, {31'd0, v.hd});
        for (int k = 1; k <= n; k++) begin
            next_cycle();
            hiloOpE = HILO_NONE;
            rsE     = 32'hDEAD_BEEF;
            rtE     = 32'h0BAD_F00D;
            #1;
            chk($sformatf("%s busy c%0d", tag, k), {31'd0, busy}, 32'd1);
            chk($sformatf("%s stall c%0d", tag, k), {31'd0, stallHiloD}, {31'd0, v.hd});
        end
        next_cycle();
        #1;
        chk({tag, " busy cN+1"}, {31'd0, busy}, 32'd0);
        chk({tag, " stall cN+1"}, {31'd0, stallHiloD}, 32'd0);
        read_hilo(v.exp_hi, v.exp_lo, tag);
        isHiloD = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        hiloOpE   = HILO_NONE;
        hiloReadE = 2'b00;
        rsE       = 32'd0;
        rtE       = 32'd0;
        isHiloD   = 1'b1;

        vecs[0] = '{HILO_MULT,  32'hFFFF_FFFD, 32'd7,          1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{HILO_MULTU, 32'hFFFF_FFFF, 32'd2,          1'b1, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{HILO_DIV,   32'hFFFF_FFF9, 32'd2,          1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{HILO_DIVU,  32'd7,         32'd2,          1'b1, 32'h0000_0001, 32'h0000_0003};
        vecs[4] = '{HILO_DIVU,  32'd5,         32'd0,          1'b1, 32'h0000_0001, 32'h0000_0003};
        vecs[5] = '{HILO_MULT,  32'h8000_0000, 32'h8000_0000,  1'b0, 32'h4000_0000, 32'h0000_0000};
        vecs[6] = '{HILO_DIV,   32'd7,         32'hFFFF_FFFE,  1'b0, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7] = '{HILO_DIVU,  32'hFFFF_FFFF, 32'd10,         1'b1, 32'h0000_0005, 32'h1999_9999};
        vecs[8] = '{HILO_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[9] = '{HILO_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF,  1'b0, 32'h0000_0000, 32'h0000_0001};

        // Reset state: outputs quiet, HI/LO cleared.
        #2;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset start", {31'd0, start}, 32'd0);
        chk("reset stall", {31'd0, stallHiloD}, 32'd0);
        read_hilo(32'd0, 32'd0, "reset");
        next_cycle();
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // mthi then mtlo in IDLE; busy never asserted.
        next_cycle();
        hiloOpE = HILO_MTHI;
        rsE     = 32'h1234_5678;
        #1;
        chk("mthi start", {31'd0, start}, 32'd0);
        chk("mthi busy", {31'd0, busy}, 32'd0);
        next_cycle();
        hiloOpE   = HILO_MTLO;
        rsE       = 32'h9ABC_DEF0;
        hiloReadE = HILO_RD_HI;
        #1;
        chk("mthi readback", hiloOutE, 32'h1234_5678);
        chk("mtlo busy", {31'd0, busy}, 32'd0);
        next_cycle();
        hiloOpE   = HILO_NONE;
        hiloReadE = HILO_RD_LO;
        #1;
        chk("mtlo readback", hiloOutE, 32'h9ABC_DEF0);
        chk("mt busy after", {31'd0, busy}, 32'd0);
        hiloReadE = 2'b00;

        // Reset on cycle 3 of a div: abort, clear, no later commit.
        next_cycle();
        hiloOpE = HILO_DIVU;
        rsE     = 32'd100;
        rtE     = 32'd7;
        #1;
        chk("rstseq start", {31'd0, start}, 32'd1);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            hiloOpE = HILO_NONE;
        end
        #1;
        chk("rstseq busy pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstseq busy async", {31'd0, busy}, 32'd0);
        read_hilo(32'd0, 32'd0, "rstseq cleared");
        next_cycle();
        #2;
        rst = 1'b0;
        for (int k = 0; k < DIV_CYC + 2; k++) begin
            next_cycle();
        end
        #1;
        chk("rstseq busy later", {31'd0, busy}, 32'd0);
        read_hilo(32'd0, 32'd0, "rstseq no commit");
        run_op('{HILO_MULT, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12}, "post-reset mult");

        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
Sequencing controller for the HI/LO multiply/divide resource in the five-stage pipeline. It sits in the E stage, consumes the decoded hiloOp, mfhi/mflo select and the forwarded rs/rt operands, and owns the HI and LO registers. It models multi-cycle mult/div latency with a busy counter, commits results at completion, and raises the D-stage stall for any HI/LO instruction that arrives while the unit is occupied.

Parameters:
MULT_CYC, 5, busy cycles for mult/multu (>=1)
DIV_CYC, 10, busy cycles for div/divu (>=1)
CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYC, DIV_CYC)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
hiloOpE  in  3  E-stage op: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none)
hiloReadE  in  2  E-stage read select: 10 mfhi, 01 mflo, else none
rsE  in  32  forwarded rs value (operand A / mthi/mtlo source)
rtE  in  32  forwarded rt value (operand B)
isHiloD  in  1  D-stage instruction is any HI/LO instruction
start  out  1  E-stage op is mult/multu/div/divu and unit idle
busy  out  1  multi-cycle operation in progress
stallHiloD  out  1  stall D stage for a HI/LO hazard
hiloOutE  out  32  HI when hiloReadE=10, LO when 01, else 0

Behaviour:
- Reset (async): state IDLE, counter 0, HI=0, LO=0, pending HI/LO=0. Outputs: busy=0; start=0 and stallHiloD=0 unless inputs request them combinationally.
- FSM: IDLE, BUSY.
- start = (state==IDLE) & hiloOpE in {001..100}. This signal is combinational.
- IDLE + start on a rising edge:
  - Compute the result and latch it into pendHI/pendLO.
  - Load the counter with MULT_CYC (mult/multu) or DIV_CYC (div/divu).
  - Go to BUSY. busy=1 from the next cycle.
- BUSY:
  - Decrement the counter each cycle.
  - When the counter is 1, then on that edge: HI<=pendHI, LO<=pendLO, state goes to IDLE.
  - busy is high for exactly N cycles (cycles 1..N after the start cycle). Results are readable from cycle N+1.
- Arithmetic:
  - mult: signed 32x32 to 64-bit product. HI=[63:32], LO=[31:0].
  - multu: same as mult, unsigned.
  - div: signed. LO=quotient (truncated toward zero), HI=remainder (sign of dividend).
  - divu: unsigned. LO=quotient, HI=remainder.
- Divide by zero: the unit still goes busy for DIV_CYC cycles. HI/LO are left unchanged at commit.
- mthi/mtlo:
  - In IDLE, HI<=rsE (or LO<=rsE) at the edge.
  - In BUSY they are ignored. The stall makes this unreachable; the verification engineer asserts it.
- mult/div while BUSY: ignored (start=0), no restart. This is unreachable by stall; assert it.
- stallHiloD = isHiloD & (start | busy).
  - One instruction per cycle enters E, so a mult in E also blocks a following mfhi in D.
- hiloOutE is combinational from the HI/LO registers only. There is no bypass from pending results; the stall guarantees correctness.
- hiloReadE=11 returns 0.
- Reset mid-operation: immediate abort, pending result discarded, HI/LO=0, busy=0.

Decomposition:
- Shared package hilo_pkg:
  - HILO_NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO encodings (3 bits). These match the decoder's hiloOpD encoding.
  - HILO_RD_HI=2'b10, HILO_RD_LO=2'b01.
  - State encoding IDLE/BUSY.
- One sub-module, md_arith: purely combinational op, a, b to hi, lo, divZero. It is instantiated once; hilo_ctrl holds all sequential logic.

Test Plan:
- mult, rsE=0xFFFFFFFD (-3), rtE=7, start at cycle 0:
  - busy=1 on cycles 1..5.
  - mfhi on cycle 6 reads 0xFFFFFFFF; mflo reads 0xFFFFFFEB.
- multu, 0xFFFFFFFF x 2 -> HI=0x00000001, LO=0xFFFFFFFE. Then div, -7 / 2 -> after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu, 7 / 2 -> LO=3, HI=1. Then divu x / 0 with HI=1, LO=3 preloaded:
  - busy for 10 cycles.
  - HI=1, LO=3 unchanged after commit.
- Stall check: mult in E with isHiloD=1 gives stallHiloD=1 on cycles 0..5 and 0 on cycle 6. With isHiloD=0, stallHiloD=0 throughout.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 in IDLE: the next-cycle reads return those values, and busy is never asserted.
- Reset asserted on cycle 3 of a div:
  - busy drops asynchronously; HI=LO=0.
  - After release, no commit occurs, and a new mult starts cleanly.
